// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for elastic pipeline stages
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [31:0] ZERO_WORD           = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_BUBBLE_PC   = ZERO_WORD;
   localparam logic [31:0] DEFAULT_BUBBLE_DATA = ZERO_WORD;
   // addi x0, x0, 0: for stages that want a NOP rather than zero as the bubble
   localparam logic [31:0] RV32_NOP            = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline register with 2-entry skid buffer
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int              PC_W        = 32,
   parameter int              DATA_W      = 32,
   parameter int              CNT_W       = 16,
   parameter logic [PC_W-1:0]   BUBBLE_PC   = PC_W'(DEFAULT_BUBBLE_PC),
   parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(DEFAULT_BUBBLE_DATA)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_t              state, state_n;
   logic [PC_W-1:0]     main_pc, skid_pc;
   logic [DATA_W-1:0]   main_data, skid_data;
   logic                in_fire, out_fire;
   logic                ld_main_in, ld_main_skid, ld_skid;

   // Handshake flags come only from the state register, so upstream sees a registered ready.
   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != FULL);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   assign out_pc   = out_valid ? main_pc   : BUBBLE_PC;
   assign out_data = out_valid ? main_data : BUBBLE_DATA;

   always_comb begin
      state_n      = state;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               state_n    = ONE;
               ld_main_in = 1'b1;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               ld_main_in = 1'b1;
            end else if (in_fire) begin
               state_n = FULL;
               ld_skid = 1'b1;
            end else if (out_fire) begin
               state_n = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_n      = ONE;
               ld_main_skid = 1'b1;
            end
         end
         default: state_n = EMPTY;
      endcase
      // A flushed cycle discards the incoming entry even if it handshook.
      if (flush) begin
         state_n      = EMPTY;
         ld_main_in   = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         main_pc   <= '0;
         main_data <= '0;
         skid_pc   <= '0;
         skid_data <= '0;
      end else begin
         state <= state_n;
         if (ld_main_in) begin
            main_pc   <= in_pc;
            main_data <= in_data;
         end else if (ld_main_skid) begin
            main_pc   <= skid_pc;
            main_data <= skid_data;
         end
         if (ld_skid) begin
            skid_pc   <= in_pc;
            skid_data <= in_data;
         end
      end
   end

   // Counts back-pressure cycles, including flush cycles; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and random scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_pc, in_data;
   logic        in_ready, out_valid, in_ready4, out_valid4;
   logic [31:0] out_pc, out_data, out_pc4, out_data4;
   logic [15:0] stall_cnt;
   logic [3:0]  stall_cnt4;

   int          nvec = 0;
   int          nfail = 0;
   logic [63:0] q[$];
   int          stall_m, stall4_m;
   bit          fired_in;
   logic [31:0] items[3];
   int          k;
   logic [31:0] seq;

   always #5 clk = ~clk;

   pipe_stage_skid dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
      .stall_cnt(stall_cnt)
   );

   pipe_stage_skid #(.CNT_W(4), .BUBBLE_DATA(RV32_NOP)) dut4 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready4), .in_pc(in_pc), .in_data(in_data),
      .out_valid(out_valid4), .out_ready(out_ready), .out_pc(out_pc4), .out_data(out_data4),
      .stall_cnt(stall_cnt4)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check outputs against the model, update the model for this cycle's inputs, then clock.
   task automatic cyc();
      bit fin, fout;
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("in_ready4", 64'(in_ready4), 64'(q.size() < 2));
      if (q.size() > 0) begin
         chk("out_valid", 64'(out_valid), 64'd1);
         chk("out_pc", 64'(out_pc), 64'(q[0][63:32]));
         chk("out_data", 64'(out_data), 64'(q[0][31:0]));
         chk("out_data4", 64'(out_data4), 64'(q[0][31:0]));
      end else begin
         chk("out_valid", 64'(out_valid), 64'd0);
         chk("bubble_pc", 64'(out_pc), 64'd0);
         chk("bubble_data", 64'(out_data), 64'd0);
         chk("bubble_pc4", 64'(out_pc4), 64'd0);
         chk("bubble_nop4", 64'(out_data4), 64'h13);
      end
      chk("out_valid4", 64'(out_valid4), 64'(q.size() > 0));
      chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
      chk("stall_cnt4", 64'(stall_cnt4), 64'(stall4_m));
      fin  = in_valid && (q.size() < 2) && !rst;
      fout = (q.size() > 0) && out_ready;
      fired_in = fin;
      if (rst) begin
         q.delete();
         stall_m  = 0;
         stall4_m = 0;
      end else begin
         if ((q.size() > 0) && !out_ready) begin
            if (stall_m < 65535) stall_m++;
            if (stall4_m < 15) stall4_m++;
         end
         if (fout) void'(q.pop_front());
         if (flush) q.delete();
         else if (fin) q.push_back({in_pc, in_data});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      stall_m = 0;
      stall4_m = 0;

      // single entry, one-cycle latency
      out_ready = 1'b1;
      cyc();
      in_valid = 1'b1; in_pc = 32'h100; in_data = 32'hDEADBEEF;
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();

      // full-rate stream
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_pc = 32'(i * 4); in_data = 32'hA000_0000 + 32'(i);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      cyc();
      chk("stream_stall", 64'(stall_cnt), 64'd0);

      // back-pressure fills the skid entry
      items[0] = 32'h0; items[1] = 32'h4; items[2] = 32'h8;
      k = 0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_pc = items[k]; in_data = 32'hB000_0000 + items[k];
         cyc();
         if (fired_in) k++;
      end
      chk("bp_accepted", 64'(k), 64'd2);
      chk("bp_stall5", 64'(stall_cnt), 64'd5);
      out_ready = 1'b1;
      while (k < 3) begin
         in_pc = items[k]; in_data = 32'hB000_0000 + items[k];
         cyc();
         if (fired_in) k++;
         if (nvec > 5000) break;
      end
      in_valid = 1'b0;
      repeat (3) cyc();

      // flush while FULL with a valid entry presented
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_pc = 32'h300; in_data = 32'h3;
      cyc();
      in_pc = 32'h304; in_data = 32'h4;
      cyc();
      flush = 1'b1; in_pc = 32'h200; in_data = 32'h2;
      cyc();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) cyc();

      // saturation of the narrow counter
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      in_valid = 1'b1; in_pc = 32'h400; in_data = 32'h44;
      cyc();
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (20) cyc();
      chk("sat_cnt4", 64'(stall_cnt4), 64'd15);
      chk("cnt16_20", 64'(stall_cnt), 64'd20);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      chk("rst_cnt4", 64'(stall_cnt4), 64'd0);

      // reset coincident with an accepted entry
      out_ready = 1'b1;
      in_valid = 1'b1; rst = 1'b1; in_pc = 32'h500; in_data = 32'h55;
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      cyc();
      cyc();

      // random traffic with occasional flush
      seq = 32'h1000;
      for (int i = 0; i < 150; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_pc     = seq;
         in_data   = ~seq;
         cyc();
         if (fired_in) seq = seq + 32'd4;
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline register for the in-order core, replacing the fixed stall-vector IF/ID latch with a valid/ready handshake. Carries a PC plus a payload of configurable width through a 2-entry skid buffer, giving full throughput with a registered `in_ready` (no combinational ready path upstream). Supports synchronous flush with bubble insertion and a saturating back-pressure counter. Instantiated between IF/ID and usable at any later stage boundary.

## Interface
- `PC_W`, 32: PC field width.
- `DATA_W`, 32: payload width (instruction word at IF/ID).
- `CNT_W`, 16: stall counter width.
- `BUBBLE_PC`, 0: `out_pc` value driven while `out_valid`=0.
- `BUBBLE_DATA`, 0: `out_data` value driven while `out_valid`=0.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all held and incoming entries.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage accepts an entry this cycle.
- `in_pc`  in  `PC_W`  upstream PC.
- `in_data`  in  `DATA_W`  upstream payload.
- `out_valid`  out  1  downstream entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_pc`  out  `PC_W`  head PC.
- `out_data`  out  `DATA_W`  head payload.
- `stall_cnt`  out  `CNT_W`  cycles with `out_valid`=1 and `out_ready`=0, saturating.

## Operation
- `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- Storage: a main entry (head, drives outputs) and a skid entry, each PC+data.
- State machine:
  - EMPTY: `in_fire` -> ONE, with main <= input.
  - ONE: `in_fire` & `out_fire` -> ONE, main <= input. `in_fire` & !`out_fire` -> FULL, skid <= input. !`in_fire` & `out_fire` -> EMPTY.
  - FULL: `in_ready`=0. `out_fire` -> ONE, main <= skid.
- `out_valid` = (state != EMPTY). `in_ready` = (state != FULL).
- While `out_valid`=0, `out_pc`/`out_data` equal `BUBBLE_PC`/`BUBBLE_DATA`. Held entry values must not leak to the outputs.
- Priority per cycle: `rst` > `flush` > handshake.
- `flush`: next state EMPTY. Any entry presented in the same cycle is discarded even when `in_fire`=1. A downstream `out_fire` in the flush cycle still counts as consumed by downstream.
- `stall_cnt`: +1 each cycle with `out_valid` & !`out_ready`, including a flush cycle. Holds at all-ones. Cleared only by `rst`; unaffected by `flush`.
- Order preserved strictly FIFO. No entry is duplicated or dropped except by `flush`.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `in_ready`=1, `out_pc`=`BUBBLE_PC`, `out_data`=`BUBBLE_DATA`, `stall_cnt`=0.
- Latency: 1 cycle. An entry accepted at edge N is visible at `out_*` after edge N.
- Throughput: 1 entry/cycle sustained with `out_ready`=1.
- `in_ready` and `out_valid` are pure functions of registered state. There is no combinational path from `in_*` or `out_ready` to any output.
- `in_ready` drops the cycle after back-pressure fills the skid entry. At most 2 entries are held.
- `rst` or `flush` asserted mid-stream: outputs show the bubble from the next cycle. `in_ready`=1 from the next cycle.
- Simultaneous `in_fire` & `out_fire` in ONE: head replaced, state unchanged, no bubble.

## Structure
- Shared package `pipe_pkg`: state enum (EMPTY, ONE, FULL), `ZERO_WORD`, and default bubble constants. The RV32 NOP constant `32'h00000013` is also defined there for stages that prefer a NOP bubble.
- Single module; no sub-module. The two storage entries are plain registers, because a FIFO sub-module would add a combinational ready.

## Test plan
- Reset, then `in_valid`=1 with pc=0x100, data=0xDEADBEEF and `out_ready`=1 -> next cycle `out_valid`=1, out_pc=0x100, out_data=0xDEADBEEF; before that, outputs 0/0.
- Stream pc 0x0,0x4,...,0x3C with `out_ready`=1 -> 16 entries in order, one per cycle, `in_ready` never low, `stall_cnt`=0.
- `out_ready`=0 for 5 cycles while feeding 0x0,0x4,0x8 -> 0x0 held, 0x4 in skid, `in_ready`=0, 0x8 not accepted until release. After release, order is 0x0,0x4,0x8 and `stall_cnt`=5.
- FULL state with `flush`=1 and `in_valid`=1 (pc=0x200) -> next cycle `out_valid`=0, outputs at bubble values, `in_ready`=1, 0x200 never emitted.
- `CNT_W`=4 with `out_ready` held 0 for 20 cycles -> `stall_cnt`=15 and holds. `rst` -> 0.
- `rst` asserted in the same cycle as `in_fire` -> next cycle state EMPTY, entry discarded.
